// File: rtl/alu_pkg.sv
// Shared opcode encoding and width default for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd11
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter for SLL/SRL, zero-fill in both directions.
module alu_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shift_right,
    output logic [WIDTH-1:0]   shifted
);

    logic [WIDTH-1:0] stage;

    // Each shamt bit selects one power-of-two stage.
    always_comb begin
        stage = data;
        for (int unsigned i = 0; i < SHAMT_W; i++) begin
            if (shamt[i]) begin
                if (shift_right) stage = stage >> (1 << i);
                else             stage = stage << (1 << i);
            end
        end
        shifted = stage;
    end

endmodule

// File: rtl/alu_core.sv
// Single-cycle MIPS execute-stage ALU with sticky signed-overflow status.
// Define ALU_OUTPUT_REG_EN to register aluResult and zero (1-cycle latency).
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = ALU_WIDTH,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   firstOperand,
    input  logic [WIDTH-1:0]   secondOperand,
    input  logic [3:0]         aluControlInput,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               clearOverflow,
    output logic [WIDTH-1:0]   aluResult,
    output logic               zero,
    output logic               overflow,
    output logic               overflowSticky
);

    alu_op_e          op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] result_c;
    logic             zero_c;
    logic             shift_right;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic             sltu;

    assign op          = alu_op_e'(aluControlInput);
    assign sum         = firstOperand + secondOperand;
    assign diff        = firstOperand - secondOperand;
    assign zero_c      = (firstOperand == secondOperand);
    assign shift_right = (op == ALU_SRL);

    assign add_ovf = (firstOperand[WIDTH-1] == secondOperand[WIDTH-1]) &&
                     (sum[WIDTH-1] != firstOperand[WIDTH-1]);
    assign sub_ovf = (firstOperand[WIDTH-1] != secondOperand[WIDTH-1]) &&
                     (diff[WIDTH-1] != firstOperand[WIDTH-1]);

    // Full-width signed compare; the truncated difference sign is wrong at overflow.
    assign slt  = ($signed(firstOperand) < $signed(secondOperand));
    assign sltu = (firstOperand < secondOperand);

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .data        (secondOperand),
        .shamt       (shamt),
        .shift_right (shift_right),
        .shifted     (shifted)
    );

    always_comb begin
        result_c = '0;
        overflow = 1'b0;
        case (op)
            ALU_AND:  result_c = firstOperand & secondOperand;
            ALU_OR:   result_c = firstOperand | secondOperand;
            ALU_ADD:  begin
                result_c = sum;
                overflow = add_ovf;
            end
            ALU_SUB:  begin
                result_c = diff;
                overflow = sub_ovf;
            end
            ALU_SLL,
            ALU_SRL:  result_c = shifted;
            ALU_SLT:  result_c = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLTU: result_c = {{(WIDTH-1){1'b0}}, sltu};
            default:  result_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             overflowSticky <= 1'b0;
        else if (clearOverflow) overflowSticky <= 1'b0;
        else if (overflow)      overflowSticky <= 1'b1;
    end

`ifdef ALU_OUTPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluResult <= '0;
            zero      <= 1'b0;
        end else begin
            aluResult <= result_c;
            zero      <= zero_c;
        end
    end
`else
    assign aluResult = result_c;
    assign zero      = zero_c;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, hand sequences, random vs. model.
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] firstOperand;
    logic [31:0] secondOperand;
    logic [3:0]  aluControlInput;
    logic [4:0]  shamt;
    logic        clearOverflow;
    logic [31:0] aluResult;
    logic        zero;
    logic        overflow;
    logic        overflowSticky;

    int checks = 0;
    int errors = 0;
    logic        sticky_m  = 1'b0;
    logic [31:0] prev_res  = '0;
    logic        prev_zero = 1'b0;

    alu_core #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .firstOperand    (firstOperand),
        .secondOperand   (secondOperand),
        .aluControlInput (aluControlInput),
        .shamt           (shamt),
        .clearOverflow   (clearOverflow),
        .aluResult       (aluResult),
        .zero            (zero),
        .overflow        (overflow),
        .overflowSticky  (overflowSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model from the opcode definitions, using 64-bit signed arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic z,
                         output logic o);
        longint sa, sb, ua, ub, t;
        longint hi, lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        hi = 64'sd2147483647;
        lo = -64'sd2147483648;
        r = '0;
        o = 1'b0;
        z = (a == b);
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin t = sa + sb; r = t[31:0]; o = (t > hi) || (t < lo); end
            4'd6: begin t = sa - sb; r = t[31:0]; o = (t > hi) || (t < lo); end
            4'd3: begin t = ub * (64'sd1 << sh); r = t[31:0]; end
            4'd4: begin t = ub / (64'sd1 << sh); r = t[31:0]; end
            4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd11: r = (ua < ub) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
    endtask

    // Drive one operation mid-cycle, check combinational outputs, then the edge effects.
    task automatic step(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic clr,
                        input logic [31:0] er, input logic ez, input logic eo);
        @(negedge clk);
        aluControlInput = op;
        firstOperand    = a;
        secondOperand   = b;
        shamt           = sh;
        clearOverflow   = clr;
        #1;
`ifdef ALU_OUTPUT_REG_EN
        chk({nm, " res_hold"}, aluResult, prev_res);
        chk({nm, " zero_hold"}, {31'd0, zero}, {31'd0, prev_zero});
`else
        chk({nm, " res"}, aluResult, er);
        chk({nm, " zero"}, {31'd0, zero}, {31'd0, ez});
`endif
        chk({nm, " ovf"}, {31'd0, overflow}, {31'd0, eo});
        sticky_m = clr ? 1'b0 : (sticky_m | eo);
        @(posedge clk);
        #1;
        chk({nm, " sticky"}, {31'd0, overflowSticky}, {31'd0, sticky_m});
`ifdef ALU_OUTPUT_REG_EN
        chk({nm, " res"}, aluResult, er);
        chk({nm, " zero"}, {31'd0, zero}, {31'd0, ez});
`endif
        prev_res  = er;
        prev_zero = ez;
    endtask

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] er;
        logic        ez;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] r, a, b;
        logic        z, o, clr;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [31:0] specials[6];

        vecs = '{
            '{"and",        4'd0,  32'd10, 32'hFFFFFFEC, 5'd0,  32'h00000008, 1'b0, 1'b0},
            '{"or",         4'd1,  32'd10, 32'hFFFFFFEC, 5'd0,  32'hFFFFFFEE, 1'b0, 1'b0},
            '{"add",        4'd2,  32'd10, 32'hFFFFFFEC, 5'd0,  32'hFFFFFFF6, 1'b0, 1'b0},
            '{"sub",        4'd6,  32'd10, 32'hFFFFFFEC, 5'd0,  32'h0000001E, 1'b0, 1'b0},
            '{"slt",        4'd7,  32'd10, 32'hFFFFFFEC, 5'd0,  32'h00000000, 1'b0, 1'b0},
            '{"sltu",       4'd11, 32'd10, 32'hFFFFFFEC, 5'd0,  32'h00000001, 1'b0, 1'b0},
            '{"op12",       4'd12, 32'd10, 32'hFFFFFFEC, 5'd0,  32'h00000000, 1'b0, 1'b0},
            '{"op5",        4'd5,  32'd10, 32'hFFFFFFEC, 5'd3,  32'h00000000, 1'b0, 1'b0},
            '{"op15",       4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1, 1'b0},
            '{"sll1",       4'd3,  32'd10, 32'hFFFFFFEC, 5'd1,  32'hFFFFFFD8, 1'b0, 1'b0},
            '{"srl1",       4'd4,  32'd10, 32'hFFFFFFEC, 5'd1,  32'h7FFFFFF6, 1'b0, 1'b0},
            '{"srl31",      4'd4,  32'd10, 32'hFFFFFFEC, 5'd31, 32'h00000001, 1'b0, 1'b0},
            '{"sll0",       4'd3,  32'd10, 32'hFFFFFFEC, 5'd0,  32'hFFFFFFEC, 1'b0, 1'b0},
            '{"srl0",       4'd4,  32'd10, 32'hFFFFFFEC, 5'd0,  32'hFFFFFFEC, 1'b0, 1'b0},
            '{"sll31",      4'd3,  32'hFFFFFFFF, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0},
            '{"add_eq",     4'd2,  32'd10, 32'd10,       5'd0,  32'd20,       1'b1, 1'b0},
            '{"add_ne",     4'd2,  32'd10, 32'd11,       5'd0,  32'd21,       1'b0, 1'b0},
            '{"and_eq",     4'd0,  32'h0F0F0F0F, 32'h0F0F0F0F, 5'd0, 32'h0F0F0F0F, 1'b1, 1'b0},
            '{"add_ovf",    4'd2,  32'h7FFFFFFF, 32'd1,  5'd0,  32'h80000000, 1'b0, 1'b1},
            '{"add_negovf", 4'd2,  32'h80000000, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1'b1},
            '{"sub_ovf",    4'd6,  32'h80000000, 32'd1,  5'd0,  32'h7FFFFFFF, 1'b0, 1'b1},
            '{"sub_ovf2",   4'd6,  32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b0, 1'b1},
            '{"slt_ext",    4'd7,  32'h80000000, 32'd1,  5'd0,  32'h00000001, 1'b0, 1'b0},
            '{"sltu_ext",   4'd11, 32'h80000000, 32'd1,  5'd0,  32'h00000000, 1'b0, 1'b0},
            '{"slt_ext2",   4'd7,  32'h7FFFFFFF, 32'h80000000, 5'd0, 32'h00000000, 1'b0, 1'b0}
        };

        rst_n           = 1'b0;
        firstOperand    = 32'd10;
        secondOperand   = 32'd10;
        aluControlInput = 4'd2;
        shamt           = '0;
        clearOverflow   = 1'b0;
        #12;
        chk("reset sticky", {31'd0, overflowSticky}, 32'd0);
`ifdef ALU_OUTPUT_REG_EN
        chk("reset res", aluResult, 32'd0);
`else
        chk("reset comb res", aluResult, 32'd20);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            step(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b0,
                 vecs[i].er, vecs[i].ez, vecs[i].eo);

        // Sticky: set, hold across benign op, clear.
        step("seq_set",   4'd2, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        step("seq_hold",  4'd1, 32'd1, 32'd2, 5'd0, 1'b0, 32'd3, 1'b0, 1'b0);
        chk("seq_hold sticky1", {31'd0, overflowSticky}, 32'd1);
        step("seq_clr",   4'd1, 32'd1, 32'd2, 5'd0, 1'b1, 32'd3, 1'b0, 1'b0);
        chk("seq_clr sticky0", {31'd0, overflowSticky}, 32'd0);

        // Clear wins over simultaneous overflow.
        step("seq_set2",  4'd6, 32'h80000000, 32'd1, 5'd0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
        step("seq_both",  4'd2, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1, 32'h80000000, 1'b0, 1'b1);
        chk("seq_both sticky0", {31'd0, overflowSticky}, 32'd0);

        // Mid-cycle asynchronous reset.
        step("seq_set3",  4'd2, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async sticky", {31'd0, overflowSticky}, 32'd0);
`ifdef ALU_OUTPUT_REG_EN
        chk("async res", aluResult, 32'd0);
        prev_res  = '0;
        prev_zero = 1'b0;
`else
        chk("async comb res", aluResult, 32'h80000000);
        chk("async comb ovf", {31'd0, overflow}, 32'd1);
`endif
        sticky_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        specials = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                     32'h00000001, 32'h80000001};
        for (int n = 0; n < 400; n++) begin
            op  = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 9) == 0) b = a;
            sh  = 5'($urandom_range(0, 31));
            clr = ($urandom_range(0, 7) == 0);
            model(op, a, b, sh, r, z, o);
            step("rand", op, a, b, sh, clr, r, z, o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Single-cycle integer ALU for the MIPS datapath execute stage.
- Computes AND/OR/ADD/SUB/SLL/SRL/SLT/SLTU on two 32-bit operands, selected by a 4-bit control code from ALU control.
- Equality flag `zero` drives the branch (beq/bne) decision.
- Clocked logic is limited to a sticky signed-overflow status register.

Parameters:
- WIDTH, 32, operand/result width
- SHAMT_W, 5, shift-amount width (log2 WIDTH)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- firstOperand  input  WIDTH  operand A (rs)
- secondOperand  input  WIDTH  operand B (rt/immediate); shifted operand for SLL/SRL
- aluControlInput  input  4  operation select
- shamt  input  SHAMT_W  shift amount
- clearOverflow  input  1  synchronous clear of overflowSticky
- aluResult  output  WIDTH  result
- zero  output  1  1 when firstOperand == secondOperand
- overflow  output  1  combinational signed overflow of the current ADD/SUB
- overflowSticky  output  1  registered sticky overflow

Behaviour:
- aluResult, zero and overflow are purely combinational, with zero latency. They settle within the same cycle as any input change.
- Op codes:
  - 0 AND: A & B
  - 1 OR: A | B
  - 2 ADD: A + B, mod 2^WIDTH
  - 3 SLL: B << shamt, zero-fill
  - 4 SRL: B >> shamt, logical, zero-fill
  - 6 SUB: A - B, mod 2^WIDTH
  - 7 SLT: signed A < B gives 1, else 0, zero-extended
  - 11 SLTU: unsigned A < B gives 1, else 0
- All other codes (5, 8, 9, 10, 12-15): aluResult = 0.
- SLL/SRL ignore firstOperand. shamt = 0 passes B through unchanged.
- zero is independent of the opcode and of aluResult. It compares the operands only.
  - Example: ADD 10+10 gives result 20 with zero = 1.
- SLT compares full two's-complement values. It must not use the sign of a truncated difference; it must be correct at overflow extremes.
- overflow:
  - ADD: 1 when A and B have the same sign and the result sign differs.
  - SUB: 1 when A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- overflowSticky:
  - Resets to 0 asynchronously when rst_n = 0.
  - On rising clk: if clearOverflow = 1, clears to 0 (clear wins over a simultaneous overflow). Otherwise ORs in overflow.
  - Reset asserted mid-operation forces 0 immediately; the combinational outputs are unaffected by reset.
- No X propagation from unused codes; every path is fully assigned.

Optional Feature:
- Macro: ALU_OUTPUT_REG_EN.
- Defined:
  - aluResult and zero are registered on rising clk, giving 1-cycle latency.
  - Both reset asynchronously to 0 when rst_n = 0.
  - overflowSticky samples the same-cycle combinational overflow as without the macro.
- Undefined: aluResult and zero are combinational, as specified above.

Decomposition:
- Package alu_pkg holds:
  - opcode constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SRL=4, ALU_SUB=6, ALU_SLT=7, ALU_SLTU=11
  - the 4-bit opcode typedef
  - the WIDTH default
- One sub-module, alu_shifter: a combinational SLL/SRL barrel shifter (data, shamt, direction -> shifted value).
- Add/sub, compare and logic ops stay inline in alu_core.

Test Plan:
- A = 10, B = -20 (0xFFFFFFEC), shamt = 0:
  - AND -> 0x00000008, zero = 0
  - OR -> 0xFFFFFFEE
  - ADD -> 0xFFFFFFF6
  - SUB -> 0x0000001E
  - SLT -> 0
  - SLTU -> 1
  - ctrl = 12 -> 0
- B = 0xFFFFFFEC, shamt = 1:
  - SLL -> 0xFFFFFFD8
  - SRL -> 0x7FFFFFF6
  - shamt = 31, SRL -> 0x00000001
  - shamt = 0 -> 0xFFFFFFEC
- A = B = 10, ADD -> result 20, zero = 1. Then A = 10, B = 11 -> zero = 0.
- Overflow on ADD:
  - A = 0x7FFFFFFF, B = 1, ADD -> result 0x80000000, overflow = 1, overflowSticky = 1 after the next clk edge.
  - Then a benign op keeps sticky at 1; clearOverflow = 1 for one cycle -> 0.
- Signed-compare extremes:
  - SUB with A = 0x80000000, B = 1 -> overflow = 1.
  - SLT with A = 0x80000000, B = 1 -> 1; SLTU with the same operands -> 0.
- Reset and clear:
  - rst_n low mid-cycle -> overflowSticky = 0 immediately, with no clock required.
  - clearOverflow asserted in the same cycle as an overflow -> sticky = 0.
  - With ALU_OUTPUT_REG_EN defined: aluResult appears exactly one clk edge after the inputs change, and is 0 during reset.
